// File: rtl/tmr0_pkg.sv
// Shared constants and types for the TMR0 counting path.
package tmr0_pkg;

  localparam int unsigned TMR0_W = 8;
  localparam logic [TMR0_W-1:0] TMR0_MAX = 8'hFF;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned INHIBIT_CYCLES_DEF = 2;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_INHIBIT = 1'b1
  } inh_state_e;

endpackage

// File: rtl/tmr0_sync.sv
// Multi-flop synchronizer for an asynchronous level plus rising-edge detector
// producing a one-cycle pulse in the clk domain.
module tmr0_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise_c
);

  logic [STAGES-1:0] r_sync;
  logic              r_dly;

  // Synchronizer chain; the extra r_dly flop is the edge-detect reference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
      r_dly  <= 1'b0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_async};
      r_dly  <= r_sync[STAGES-1];
    end
  end

  assign o_rise_c = r_sync[STAGES-1] & ~r_dly;

endmodule

// File: rtl/tmr0_counter.sv
// TMR0 register, overflow flag, interrupt qualification and CPU write handling.
// Optional post-write increment inhibit enabled by defining TMR0_INHIBIT_EN.
module tmr0_counter
  import tmr0_pkg::*;
#(
  parameter int unsigned SYNC_STAGES    = SYNC_STAGES_DEF,
  parameter int unsigned INHIBIT_CYCLES = INHIBIT_CYCLES_DEF
) (
  input  logic              oscIn,
  input  logic              reset,
  input  logic              tick,
  input  logic              wr_en,
  input  logic [TMR0_W-1:0] wr_data,
  input  logic              clr_if,
  input  logic              t0ie,
  input  logic              gie,
  output logic [TMR0_W-1:0] tmr0out,
  output logic              t0if,
  output logic              irq,
  output logic              ps_clr
);

  logic              w_inc;
  logic              w_inhibit;
  logic              w_ovf;
  logic [TMR0_W-1:0] w_tmr_nxt;
  logic              w_t0if_nxt;
  logic [TMR0_W-1:0] r_tmr;
  logic              r_t0if;
  logic              r_ps_clr;

  tmr0_sync #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (oscIn),
    .rst_n    (reset),
    .i_async  (tick),
    .o_rise_c (w_inc)
  );

`ifdef TMR0_INHIBIT_EN
  localparam int unsigned INH_W = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES + 1) : 1;

  inh_state_e       r_state;
  inh_state_e       w_state_nxt;
  logic [INH_W-1:0] r_inh_cnt;
  logic [INH_W-1:0] w_inh_cnt_nxt;

  always_ff @(posedge oscIn or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_inh_cnt <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_inh_cnt <= w_inh_cnt_nxt;
    end
  end

  // Inhibit window: every write (re)arms it, then it drains one per cycle.
  always_comb begin
    w_state_nxt   = r_state;
    w_inh_cnt_nxt = r_inh_cnt;
    case (r_state)
      ST_IDLE: begin
        if (wr_en && (INHIBIT_CYCLES != 0)) begin
          w_state_nxt   = ST_INHIBIT;
          w_inh_cnt_nxt = INH_W'(INHIBIT_CYCLES);
        end
      end
      ST_INHIBIT: begin
        if (wr_en) begin
          w_inh_cnt_nxt = INH_W'(INHIBIT_CYCLES);
        end else if (r_inh_cnt <= INH_W'(1)) begin
          w_state_nxt   = ST_IDLE;
          w_inh_cnt_nxt = '0;
        end else begin
          w_inh_cnt_nxt = r_inh_cnt - INH_W'(1);
        end
      end
      default: begin
        w_state_nxt   = ST_IDLE;
        w_inh_cnt_nxt = '0;
      end
    endcase
  end

  assign w_inhibit = (r_state == ST_INHIBIT);
`else
  logic w_unused_inh;
  assign w_unused_inh = (INHIBIT_CYCLES != 0);
  assign w_inhibit    = 1'b0;
`endif

  // A write always beats a same-cycle increment, so it can never overflow.
  always_comb begin
    w_tmr_nxt = r_tmr;
    w_ovf     = 1'b0;
    if (wr_en) begin
      w_tmr_nxt = wr_data;
    end else if (w_inc && !w_inhibit) begin
      w_ovf     = (r_tmr == TMR0_MAX);
      w_tmr_nxt = r_tmr + TMR0_W'(1);
    end
    w_t0if_nxt = w_ovf | (r_t0if & ~clr_if);
  end

  always_ff @(posedge oscIn or negedge reset) begin
    if (!reset) begin
      r_tmr    <= '0;
      r_t0if   <= 1'b0;
      r_ps_clr <= 1'b0;
    end else begin
      r_tmr    <= w_tmr_nxt;
      r_t0if   <= w_t0if_nxt;
      r_ps_clr <= wr_en;
    end
  end

  assign tmr0out = r_tmr;
  assign t0if    = r_t0if;
  assign ps_clr  = r_ps_clr;
  assign irq     = r_t0if & t0ie & gie;

endmodule

// File: tb/tb_tmr0_counter.sv
// Self-checking bench for tmr0_counter; honours TMR0_INHIBIT_EN like the design.
module tb_tmr0_counter;

  localparam int unsigned SYNC = 2;
  localparam int unsigned INH  = 2;
`ifdef TMR0_INHIBIT_EN
  localparam bit INH_EN = 1'b1;
`else
  localparam bit INH_EN = 1'b0;
`endif

  logic       oscIn;
  logic       reset;
  logic       tick;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       clr_if;
  logic       t0ie;
  logic       gie;
  logic [7:0] tmr0out;
  logic       t0if;
  logic       irq;
  logic       ps_clr;

  int errs   = 0;
  int checks = 0;

  // Reference model: history of tick samples per edge, edge index of last write.
  logic [7:0] m_tmr;
  bit         m_if;
  bit         m_ps;
  int         m_n;
  int         m_lastw;
  bit         q[$];

  tmr0_counter #(
    .SYNC_STAGES    (SYNC),
    .INHIBIT_CYCLES (INH)
  ) dut (
    .oscIn   (oscIn),
    .reset   (reset),
    .tick    (tick),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .clr_if  (clr_if),
    .t0ie    (t0ie),
    .gie     (gie),
    .tmr0out (tmr0out),
    .t0if    (t0if),
    .irq     (irq),
    .ps_clr  (ps_clr)
  );

  initial oscIn = 1'b0;
  always #5 oscIn = ~oscIn;

  task automatic model_reset();
    m_tmr   = 8'h00;
    m_if    = 1'b0;
    m_ps    = 1'b0;
    m_n     = 0;
    m_lastw = -1000;
    q.delete();
    for (int i = 0; i < int'(SYNC) + 2; i++) q.push_back(1'b0);
  endtask

  // Apply inputs for the next rising edge, predict its effect, then wait to the falling edge.
  task automatic drive(input bit tk, input bit wr, input logic [7:0] d, input bit clr);
    bit inc;
    bit inh;
    bit ovf;
    tick    = tk;
    wr_en   = wr;
    wr_data = d;
    clr_if  = clr;
    q.push_front(tk);
    inc = q[SYNC] && !q[SYNC+1];
    void'(q.pop_back());
    inh = INH_EN && ((m_n - m_lastw) >= 1) && ((m_n - m_lastw) <= int'(INH));
    ovf = 1'b0;
    if (wr) begin
      m_tmr   = d;
      m_lastw = m_n;
    end else if (inc && !inh) begin
      ovf   = (m_tmr == 8'hFF);
      m_tmr = m_tmr + 8'd1;
    end
    if (ovf) m_if = 1'b1;
    else if (clr) m_if = 1'b0;
    m_ps = wr;
    m_n++;
    @(negedge oscIn);
  endtask

  task automatic pulse(input int hi, input int lo);
    for (int i = 0; i < hi; i++) drive(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < lo; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic test_reset();
    reset = 1'b0; tick = 1'b0; wr_en = 1'b0; wr_data = 8'h00;
    clr_if = 1'b0; t0ie = 1'b1; gie = 1'b1;
    repeat (3) @(negedge oscIn);
    reset = 1'b1;
    model_reset();
    idle(2);
    checks++; if (tmr0out !== 8'h00) begin errs++; $display("FAIL reset_tmr0out: got %h expected 00", tmr0out); end
    checks++; if (t0if !== 1'b0) begin errs++; $display("FAIL reset_t0if: got %b expected 0", t0if); end
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (ps_clr !== 1'b0) begin errs++; $display("FAIL reset_ps_clr: got %b expected 0", ps_clr); end
  endtask

  task automatic test_count();
    logic [7:0] exp;
    t0ie = 1'b0; gie = 1'b0;
    for (int p = 0; p < 5; p++) begin
      for (int c = 0; c < 8; c++) begin
        drive(c < 4, 1'b0, 8'h00, 1'b0);
        exp = 8'(p + ((c >= 2) ? 1 : 0));
        checks++;
        if (tmr0out !== exp) begin
          errs++; $display("FAIL count_latency p%0d c%0d: got %h expected %h", p, c, tmr0out, exp);
        end
      end
    end
    checks++; if (tmr0out !== 8'h05) begin errs++; $display("FAIL count_final: got %h expected 05", tmr0out); end
    checks++; if (t0if !== 1'b0) begin errs++; $display("FAIL count_t0if: got %b expected 0", t0if); end
  endtask

  task automatic test_overflow();
    drive(1'b0, 1'b1, 8'hFE, 1'b0);
    idle(3);
    pulse(4, 4);
    checks++; if (tmr0out !== 8'hFF) begin errs++; $display("FAIL ovf_ff: got %h expected ff", tmr0out); end
    checks++; if (t0if !== 1'b0) begin errs++; $display("FAIL ovf_pre_t0if: got %b expected 0", t0if); end
    pulse(4, 4);
    checks++; if (tmr0out !== 8'h00) begin errs++; $display("FAIL ovf_wrap: got %h expected 00", tmr0out); end
    checks++; if (t0if !== 1'b1) begin errs++; $display("FAIL ovf_t0if: got %b expected 1", t0if); end
    t0ie = 1'b1; gie = 1'b1; #1;
    checks++; if (irq !== 1'b1) begin errs++; $display("FAIL ovf_irq_on: got %b expected 1", irq); end
    t0ie = 1'b0; #1;
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL ovf_irq_t0ie_off: got %b expected 0", irq); end
  endtask

  task automatic test_write_inhibit();
    int ps_cnt;
    logic [7:0] exp;
    exp = INH_EN ? 8'h10 : 8'h11;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h10, 1'b0);
    ps_cnt = int'(ps_clr);
    checks++; if (tmr0out !== 8'h10) begin errs++; $display("FAIL wr_value: got %h expected 10", tmr0out); end
    checks++; if (ps_clr !== 1'b1) begin errs++; $display("FAIL wr_ps_clr: got %b expected 1", ps_clr); end
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    ps_cnt += int'(ps_clr);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0);
      ps_cnt += int'(ps_clr);
    end
    checks++; if (tmr0out !== exp) begin errs++; $display("FAIL wr_inhibit: got %h expected %h", tmr0out, exp); end
    checks++; if (ps_cnt != 1) begin errs++; $display("FAIL wr_ps_once: got %0d pulses expected 1", ps_cnt); end
    checks++; if (t0if !== 1'b1) begin errs++; $display("FAIL wr_keeps_t0if: got %b expected 1", t0if); end
  endtask

  task automatic test_write_wins();
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    drive(1'b0, 1'b1, 8'hFF, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h3C, 1'b0);
    checks++; if (tmr0out !== 8'h3C) begin errs++; $display("FAIL wins_value: got %h expected 3c", tmr0out); end
    checks++; if (t0if !== 1'b0) begin errs++; $display("FAIL wins_no_ovf: got %b expected 0", t0if); end
    idle(4);
    checks++; if (tmr0out !== 8'h3C) begin errs++; $display("FAIL wins_dropped: got %h expected 3c", tmr0out); end
  endtask

  task automatic test_clr_overflow();
    drive(1'b0, 1'b1, 8'hFF, 1'b0);
    idle(3);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b1);
    checks++; if (tmr0out !== 8'h00) begin errs++; $display("FAIL clr_wrap: got %h expected 00", tmr0out); end
    checks++; if (t0if !== 1'b1) begin errs++; $display("FAIL clr_set_wins: got %b expected 1", t0if); end
    drive(1'b0, 1'b0, 8'h00, 1'b1);
    checks++; if (t0if !== 1'b0) begin errs++; $display("FAIL clr_next: got %b expected 0", t0if); end
    idle(3);
  endtask

  task automatic test_reset_mid();
    drive(1'b0, 1'b1, 8'hFF, 1'b0);
    idle(3);
    pulse(4, 4);
    drive(1'b0, 1'b1, 8'h79, 1'b0);
    idle(3);
    pulse(4, 4);
    checks++; if (tmr0out !== 8'h7A) begin errs++; $display("FAIL mid_pre_value: got %h expected 7a", tmr0out); end
    checks++; if (t0if !== 1'b1) begin errs++; $display("FAIL mid_pre_t0if: got %b expected 1", t0if); end
    t0ie = 1'b1; gie = 1'b1;
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    #2 reset = 1'b0;
    #1;
    checks++; if (tmr0out !== 8'h00) begin errs++; $display("FAIL mid_rst_tmr0out: got %h expected 00", tmr0out); end
    checks++; if (t0if !== 1'b0) begin errs++; $display("FAIL mid_rst_t0if: got %b expected 0", t0if); end
    checks++; if (irq !== 1'b0) begin errs++; $display("FAIL mid_rst_irq: got %b expected 0", irq); end
    checks++; if (ps_clr !== 1'b0) begin errs++; $display("FAIL mid_rst_ps_clr: got %b expected 0", ps_clr); end
    tick = 1'b0;
    repeat (2) @(negedge oscIn);
    reset = 1'b1;
    model_reset();
    idle(5);
    checks++; if (tmr0out !== 8'h00) begin errs++; $display("FAIL mid_no_count: got %h expected 00", tmr0out); end
    pulse(4, 4);
    checks++; if (tmr0out !== 8'h01) begin errs++; $display("FAIL mid_fresh_edge: got %h expected 01", tmr0out); end
  endtask

  task automatic test_random();
    int hold;
    bit tk;
    bit wr;
    bit clr;
    logic [7:0] d;
    hold = 0;
    tk = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if (hold == 0) begin
        tk = ~tk;
        hold = int'($urandom_range(2, 6));
      end
      hold--;
      if (i % 20 == 0) begin
        t0ie = 1'($urandom % 2);
        gie  = 1'($urandom % 2);
      end
      wr  = ($urandom % 16) == 0;
      clr = ($urandom % 16) == 0;
      d   = ($urandom % 2 == 0) ? 8'($urandom_range(250, 255)) : 8'($urandom);
      drive(tk, wr, d, clr);
      checks++; if (tmr0out !== m_tmr) begin errs++; $display("FAIL rnd_tmr0out @%0d: got %h expected %h", i, tmr0out, m_tmr); end
      checks++; if (t0if !== m_if) begin errs++; $display("FAIL rnd_t0if @%0d: got %b expected %b", i, t0if, m_if); end
      checks++; if (ps_clr !== m_ps) begin errs++; $display("FAIL rnd_ps_clr @%0d: got %b expected %b", i, ps_clr, m_ps); end
      checks++; if (irq !== (m_if & t0ie & gie)) begin errs++; $display("FAIL rnd_irq @%0d: got %b expected %b", i, irq, m_if & t0ie & gie); end
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_overflow();
    test_write_inhibit();
    test_write_wins();
    test_clr_overflow();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d checks=%0d", errs, checks);
    $fatal(1, "timeout");
  end

endmodule
